// File: rtl/alu_seq_pkg.sv
// Shared opcodes, FSM state type and sizing for the ALU command sequencer.
package alu_seq_pkg;

  localparam int NUM_REGS = 8;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_MUL = 4'd2;
  localparam logic [3:0] OP_DIV = 4'd3;
  localparam logic [3:0] OP_SHL1 = 4'd4;
  localparam logic [3:0] OP_SHR1 = 4'd5;
  localparam logic [3:0] OP_SHL2 = 4'd6;
  localparam logic [3:0] OP_SHR2 = 4'd7;
  localparam logic [3:0] OP_AND = 4'd8;
  localparam logic [3:0] OP_OR = 4'd9;
  localparam logic [3:0] OP_XOR = 4'd10;
  localparam logic [3:0] OP_MAX = 4'd10;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    CAPTURE,
    RESPOND
  } state_t;

  function automatic logic op_legal(input logic [3:0] op);
    return op <= OP_MAX;
  endfunction

endpackage

// File: rtl/alu_cmd_sequencer_if.sv
// Command, ALU and response signals of the sequencer, bundled for port connection.
// Handshakes: a transfer happens on a rising edge where valid && ready; the
// offering side keeps valid and its payload steady until that edge.
interface alu_cmd_sequencer_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [3:0]  cmd_op;
  logic [2:0]  cmd_dst;
  logic [2:0]  cmd_src1;
  logic [2:0]  cmd_src2;
  logic        cmd_imm_en;
  logic [15:0] cmd_imm;

  logic [15:0] alu_operand1;
  logic [15:0] alu_operand2;
  logic [3:0]  alu_operation;
  logic [15:0] alu_result;
  logic [15:0] alu_rest;
  logic        alu_zero;

  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_result;
  logic [15:0] rsp_rest;
  logic        rsp_zero;
  logic        rsp_err;
  logic [2:0]  rsp_dst;

  modport master (
    output cmd_valid, cmd_op, cmd_dst, cmd_src1, cmd_src2, cmd_imm_en, cmd_imm,
    input  cmd_ready,
    input  alu_operand1, alu_operand2, alu_operation,
    output alu_result, alu_rest, alu_zero,
    input  rsp_valid, rsp_result, rsp_rest, rsp_zero, rsp_err, rsp_dst,
    output rsp_ready
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_dst, cmd_src1, cmd_src2, cmd_imm_en, cmd_imm,
    output cmd_ready,
    output alu_operand1, alu_operand2, alu_operation,
    input  alu_result, alu_rest, alu_zero,
    output rsp_valid, rsp_result, rsp_rest, rsp_zero, rsp_err, rsp_dst,
    input  rsp_ready
  );
endinterface

// File: rtl/alu_seq_regfile.sv
// 8 x 16 register file: r0 hard-wired to zero, two operand reads, one debug read, one write.
module alu_seq_regfile
  import alu_seq_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  raddr1,
  output logic [15:0] rdata1,
  input  logic [2:0]  raddr2,
  output logic [15:0] rdata2,
  input  logic [2:0]  dbg_addr,
  output logic [15:0] dbg_data,
  input  logic        we,
  input  logic [2:0]  waddr,
  input  logic [15:0] wdata
);

  logic [15:0] regs [NUM_REGS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (we && (waddr != 3'd0)) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata1   = (raddr1 == 3'd0) ? 16'd0 : regs[raddr1];
  assign rdata2   = (raddr2 == 3'd0) ? 16'd0 : regs[raddr2];
  assign dbg_data = (dbg_addr == 3'd0) ? 16'd0 : regs[dbg_addr];

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Accepts register/immediate ALU commands, drives an external ALU, waits for it
// to settle, writes the result back and returns a response.
module alu_cmd_sequencer
  import alu_seq_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                clk,
  input  logic                rst,
  alu_cmd_sequencer_if.slave  bus,
  input  logic [2:0]          rd_addr,
  output logic [15:0]         rd_data,
  output state_t              state
);

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [2:0]  dst_q;
  logic        err_q;
  logic [15:0] src1_data, src2_data, op2_sel;
  logic        accept, legal, div0, we;

  alu_seq_regfile u_regfile (
    .clk      (clk),
    .rst      (rst),
    .raddr1   (bus.cmd_src1),
    .rdata1   (src1_data),
    .raddr2   (bus.cmd_src2),
    .rdata2   (src2_data),
    .dbg_addr (rd_addr),
    .dbg_data (rd_data),
    .we       (we),
    .waddr    (dst_q),
    .wdata    (bus.alu_result)
  );

  assign op2_sel       = bus.cmd_imm_en ? bus.cmd_imm : src2_data;
  assign bus.cmd_ready = (state_q == IDLE);
  assign bus.rsp_valid = (state_q == RESPOND);
  assign accept        = bus.cmd_valid && bus.cmd_ready;
  assign legal         = op_legal(bus.cmd_op);
  assign div0          = (bus.cmd_op == OP_DIV) && (op2_sel == 16'd0);
  assign we            = (state_q == CAPTURE) && !err_q;
  assign state         = state_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // ISSUE spends one cycle letting the freshly registered operands reach the
  // ALU, then SETTLE_CYCLES more; error commands skip it and pass through
  // CAPTURE without touching the ALU result or the register file.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          cnt_d   = '0;
          state_d = (legal && !div0) ? ISSUE : CAPTURE;
        end
      end
      ISSUE: begin
        if (cnt_q == SETTLE_LAST) state_d = CAPTURE;
        else                      cnt_d   = cnt_q + 4'd1;
      end
      CAPTURE: state_d = RESPOND;
      RESPOND: if (bus.rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.alu_operand1  <= '0;
      bus.alu_operand2  <= '0;
      bus.alu_operation <= 4'hF;
      bus.rsp_result    <= '0;
      bus.rsp_rest      <= '0;
      bus.rsp_zero      <= 1'b0;
      bus.rsp_err       <= 1'b0;
      bus.rsp_dst       <= '0;
      dst_q             <= '0;
      err_q             <= 1'b0;
    end else begin
      if (accept) begin
        dst_q <= bus.cmd_dst;
        err_q <= !legal || div0;
        if (legal) begin
          bus.alu_operand1  <= src1_data;
          bus.alu_operand2  <= op2_sel;
          bus.alu_operation <= bus.cmd_op;
        end
        if (!legal) begin
          bus.rsp_result <= 16'd0;
          bus.rsp_rest   <= 16'd0;
          bus.rsp_zero   <= 1'b1;
          bus.rsp_err    <= 1'b1;
          bus.rsp_dst    <= bus.cmd_dst;
        end else if (div0) begin
          bus.rsp_result <= 16'hFFFF;
          bus.rsp_rest   <= src1_data;
          bus.rsp_zero   <= 1'b0;
          bus.rsp_err    <= 1'b1;
          bus.rsp_dst    <= bus.cmd_dst;
        end
      end
      if (we) begin
        bus.rsp_result <= bus.alu_result;
        bus.rsp_rest   <= (bus.alu_operation == OP_DIV) ? bus.alu_rest : 16'd0;
        bus.rsp_zero   <= bus.alu_zero;
        bus.rsp_err    <= 1'b0;
        bus.rsp_dst    <= dst_q;
      end
    end
  end

endmodule
